packet_limiter: RTL and testbench

- Stream-conditioning stage that sits directly upstream of packet_fifo and drives its valid_i/ready_o/last_i/drop_i/data_i write port.
- Enforces a maximum packet length: oversize packets are truncated and tagged with drop, and the rest of the source packet is discarded.
- Propagates source drop requests and keeps saturating counts of good and dropped packets.
- Provides a registered, full-throughput boundary so packet_fifo's ready timing never reaches the source.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/axis_skid.sv | 68 ++++++
 rtl/packet_limiter.sv | 124 ++++++++++++
 tb/tb_packet_limiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the packet_fifo write-side stages: limiter state
// encoding and a constant-evaluable ceiling log2 used to size counters.
package fifo_pkg;

  typedef enum logic {
    ST_PASS    = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_skid.sv
// Two-entry registered stream stage (main + spill). Both ready_o and valid_o
// come straight from flops, so downstream ready timing never reaches upstream.
module axis_skid #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  // Handshake: a beat moves on a port in any cycle where its valid and ready
  // are both high at the rising edge; a presented beat is held until taken.
  logic             main_valid, main_valid_n;
  logic [WIDTH-1:0] main_q, main_n;
  logic             spill_valid, spill_valid_n;
  logic [WIDTH-1:0] spill_q, spill_n;
  logic             ready_q;
  logic             accept;

  assign accept = valid_i && ready_q;

  always_comb begin
    main_valid_n  = main_valid;
    main_n        = main_q;
    spill_valid_n = spill_valid;
    spill_n       = spill_q;
    if (!main_valid || ready_i) begin
      if (spill_valid) begin
        main_valid_n  = 1'b1;
        main_n        = spill_q;
        spill_valid_n = 1'b0;
      end else begin
        main_valid_n = accept;
        if (accept) main_n = data_i;
      end
    end else if (accept) begin
      // Main is stalled: park the incoming beat so upstream sees no stall yet.
      spill_valid_n = 1'b1;
      spill_n       = data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      main_valid  <= 1'b0;
      main_q      <= '0;
      spill_valid <= 1'b0;
      spill_q     <= '0;
      ready_q     <= 1'b0;
    end else begin
      main_valid  <= main_valid_n;
      main_q      <= main_n;
      spill_valid <= spill_valid_n;
      spill_q     <= spill_n;
      ready_q     <= !spill_valid_n;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = main_valid;
  assign data_o  = main_q;

endmodule

// File: rtl/packet_limiter.sv
// Caps packet length ahead of packet_fifo: oversize packets are cut, tagged
// for drop and their tail swallowed; keeps saturating good/dropped counts.
module packet_limiter
  import fifo_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MAXLEN = 64,
  parameter int CBITS  = 16,
  parameter int LBITS  = clog2(MAXLEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             last_i,
  input  logic             drop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o,
  output logic             drop_o,
  output logic [WIDTH-1:0] data_o,
  output logic [LBITS-1:0] length_o,
  output logic [CBITS-1:0] pkts_o,
  output logic [CBITS-1:0] drops_o
);

  state_t           state, state_n;
  logic [LBITS-1:0] length_q, length_n;
  logic             sticky_q, sticky_n;
  logic [CBITS-1:0] pkts_q, drops_q;

  logic             accept;
  logic             overflow;
  logic             fwd_valid;
  logic             fwd_last;
  logic             fwd_drop;
  logic             skid_ready;
  logic [WIDTH+1:0] skid_out;
  logic             out_end;

  // While discarding, the source is drained at full rate independent of the
  // output side; otherwise acceptance follows the skid's registered ready.
  assign ready_o  = (state == ST_DISCARD) || skid_ready;
  assign accept   = valid_i && ready_o;
  assign overflow = (length_q == LBITS'(MAXLEN - 1)) && !last_i;

  always_comb begin
    state_n   = state;
    length_n  = length_q;
    sticky_n  = sticky_q;
    fwd_valid = 1'b0;
    fwd_last  = last_i || overflow;
    fwd_drop  = sticky_q || drop_i || overflow;
    case (state)
      ST_PASS: begin
        fwd_valid = valid_i;
        if (accept) begin
          if (last_i || overflow) begin
            length_n = '0;
            sticky_n = 1'b0;
          end else begin
            length_n = length_q + 1'b1;
            sticky_n = sticky_q || drop_i;
          end
          if (overflow) state_n = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (accept && last_i) state_n = ST_PASS;
      end
      default: state_n = ST_PASS;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_PASS;
      length_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      state    <= state_n;
      length_q <= length_n;
      sticky_q <= sticky_n;
    end
  end

  axis_skid #(
    .WIDTH(WIDTH + 2)
  ) u_skid (
    .clock  (clock),
    .reset  (reset),
    .valid_i(fwd_valid),
    .ready_o(skid_ready),
    .data_i ({fwd_drop, fwd_last, data_i}),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (skid_out)
  );

  assign drop_o = skid_out[WIDTH+1];
  assign last_o = skid_out[WIDTH];
  assign data_o = skid_out[WIDTH-1:0];

  assign out_end = valid_o && ready_i && last_o;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pkts_q  <= '0;
      drops_q <= '0;
    end else if (out_end) begin
      if (drop_o) begin
        if (drops_q != {CBITS{1'b1}}) drops_q <= drops_q + 1'b1;
      end else begin
        if (pkts_q != {CBITS{1'b1}}) pkts_q <= pkts_q + 1'b1;
      end
    end
  end

  assign length_o = length_q;
  assign pkts_o   = pkts_q;
  assign drops_o  = drops_q;

endmodule

// File: tb/tb_packet_limiter.sv
// Directed bench for packet_limiter with MAXLEN=8 and CBITS=2 so truncation
// and counter saturation are reached with short packets.
module tb_packet_limiter;

  localparam int WIDTH  = 8;
  localparam int MAXLEN = 8;
  localparam int CBITS  = 2;
  localparam int LBITS  = 4;
  localparam int PERIOD = 10;

  logic             clock;
  logic             reset;
  logic             valid_i;
  logic             ready_o;
  logic             last_i;
  logic             drop_i;
  logic [WIDTH-1:0] data_i;
  logic             valid_o;
  logic             ready_i;
  logic             last_o;
  logic             drop_o;
  logic [WIDTH-1:0] data_o;
  logic [LBITS-1:0] length_o;
  logic [CBITS-1:0] pkts_o;
  logic [CBITS-1:0] drops_o;

  packet_limiter #(
    .WIDTH (WIDTH),
    .MAXLEN(MAXLEN),
    .CBITS (CBITS)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .last_i  (last_i),
    .drop_i  (drop_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .last_o  (last_o),
    .drop_o  (drop_o),
    .data_o  (data_o),
    .length_o(length_o),
    .pkts_o  (pkts_o),
    .drops_o (drops_o)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #(PERIOD / 2) clock = ~clock;

  // ---------------- scoreboard state ----------------
  // Beats are packed as {drop, last, data}.
  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] got_q[$];
  int               total;
  int               passed;
  logic             stream_done;

  always @(negedge clock) begin
    if (reset && valid_o && ready_i) got_q.push_back({drop_o, last_o, data_o});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset   = 1'b0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    drop_i  = 1'b0;
    data_i  = '0;
    ready_i = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_pkts", 32'(pkts_o), 0);
    chk("rst_drops", 32'(drops_o), 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rel_ready", 32'(ready_o), 1);
    chk("rel_length", 32'(length_o), 0);
    got_q.delete();
    exp_q.delete();
  endtask

  // Presents one beat and returns 1 ns after the edge that accepted it.
  task automatic send(input logic [WIDTH-1:0] d, input logic l, input logic dr);
    int n;
    n       = 0;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    drop_i  = dr;
    @(negedge clock);
    while (!ready_o && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    last_i  = 1'b0;
    drop_i  = 1'b0;
  endtask

  task automatic expect_beat(input logic [WIDTH-1:0] d, input logic l, input logic dr);
    exp_q.push_back({dr, l, d});
  endtask

  task automatic drain();
    repeat (6) @(posedge clock);
    #1;
  endtask

  task automatic compare_beats(input string tag);
    int n;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    longint t0;
    longint t1;
    total       = 0;
    passed      = 0;
    stream_done = 1'b0;

    // 1: plain 5-beat packet, one-cycle latency
    do_reset();
    chk("p1_idle_valid", 32'(valid_o), 0);
    for (int i = 0; i < 5; i++) begin
      send(WIDTH'(i), i == 4, 1'b0);
      expect_beat(WIDTH'(i), i == 4, 1'b0);
      if (i == 0) begin
        chk("p1_latency_valid", 32'(valid_o), 1);
        chk("p1_latency_data", 32'(data_o), 0);
      end
      if (i == 2) chk("p1_length3", 32'(length_o), 3);
    end
    idle();
    drain();
    compare_beats("p1");
    chk("p1_pkts", 32'(pkts_o), 1);
    chk("p1_drops", 32'(drops_o), 0);
    chk("p1_length_end", 32'(length_o), 0);

    // 2: 12-beat packet cut at 8, tail swallowed, then a 3-beat packet
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send(WIDTH'(i), i == 11, 1'b0);
      if (i < 7) expect_beat(WIDTH'(i), 1'b0, 1'b0);
      if (i == 7) begin
        expect_beat(WIDTH'(7), 1'b1, 1'b1);
        chk("p2_length_cleared", 32'(length_o), 0);
        chk("p2_discard_ready", 32'(ready_o), 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      send(WIDTH'(8'h20 + i), i == 2, 1'b0);
      expect_beat(WIDTH'(8'h20 + i), i == 2, 1'b0);
    end
    idle();
    drain();
    compare_beats("p2");
    chk("p2_drops", 32'(drops_o), 1);
    chk("p2_pkts", 32'(pkts_o), 1);

    // 3: exactly MAXLEN beats passes; a following 1-beat packet is forwarded
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(WIDTH'(8'h30 + i), i == 7, 1'b0);
      expect_beat(WIDTH'(8'h30 + i), i == 7, 1'b0);
    end
    send(8'h55, 1'b1, 1'b0);
    expect_beat(8'h55, 1'b1, 1'b0);
    idle();
    drain();
    compare_beats("p3");
    chk("p3_pkts", 32'(pkts_o), 2);
    chk("p3_drops", 32'(drops_o), 0);

    // 4: drop requested on beat 2 only; next packet is clean
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(WIDTH'(8'h10 + i), i == 3, i == 1);
      expect_beat(WIDTH'(8'h10 + i), i == 3, i >= 1);
    end
    send(8'h20, 1'b0, 1'b0);
    expect_beat(8'h20, 1'b0, 1'b0);
    send(8'h21, 1'b1, 1'b0);
    expect_beat(8'h21, 1'b1, 1'b0);
    idle();
    drain();
    compare_beats("p4");
    chk("p4_drops", 32'(drops_o), 1);
    chk("p4_pkts", 32'(pkts_o), 1);

    // 5: 20-beat stream with ready_i toggling, then full-rate check
    do_reset();
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send(WIDTH'(8'h40 + i), (i % 4) == 3, 1'b0);
          expect_beat(WIDTH'(8'h40 + i), (i % 4) == 3, 1'b0);
        end
        idle();
        stream_done = 1'b1;
      end
      begin
        for (int c = 0; c < 400 && !stream_done; c++) begin
          @(posedge clock);
          #1;
          ready_i = ~ready_i;
        end
      end
    join
    ready_i = 1'b1;
    drain();
    compare_beats("p5_toggle");
    t0 = $time;
    for (int i = 0; i < 4; i++) begin
      send(WIDTH'(8'h60 + i), i == 3, 1'b0);
      expect_beat(WIDTH'(8'h60 + i), i == 3, 1'b0);
    end
    t1 = $time;
    idle();
    chk("p5_rate", 32'(t1 - t0), 32'(4 * PERIOD));
    drain();
    compare_beats("p5_full");
    chk("p5_pkts_sat", 32'(pkts_o), 3);
    chk("p5_drops", 32'(drops_o), 0);

    // 6: counter saturation, then reset mid-packet
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(WIDTH'(8'h80 + i), 1'b1, 1'b0);
      idle();
      @(posedge clock);
      #1;
      chk($sformatf("p6_pkts%0d", i), 32'(pkts_o), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    drain();
    ready_i = 1'b0;
    send(8'h90, 1'b0, 1'b0);
    send(8'h91, 1'b0, 1'b0);
    idle();
    got_q.delete();
    exp_q.delete();
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("p6_rst_valid", 32'(valid_o), 0);
    chk("p6_rst_pkts", 32'(pkts_o), 0);
    chk("p6_rst_drops", 32'(drops_o), 0);
    reset   = 1'b1;
    ready_i = 1'b1;
    @(posedge clock);
    #1;
    chk("p6_rel_ready", 32'(ready_o), 1);
    send(8'h70, 1'b0, 1'b0);
    expect_beat(8'h70, 1'b0, 1'b0);
    send(8'h71, 1'b1, 1'b0);
    expect_beat(8'h71, 1'b1, 1'b0);
    idle();
    drain();
    compare_beats("p6_fresh");
    chk("p6_pkts_after", 32'(pkts_o), 1);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
